// File: rtl/wave_gen_pkg.sv
// Shared types and reset constants for the parameterised waveform generator.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        SQUARE = 2'b00,
        SAW    = 2'b01,
        TRI    = 2'b10,
        OFF    = 2'b11
    } wave_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } tri_dir_e;

    localparam int unsigned SHADOW_AMP_RST  = 0;
    localparam int unsigned SHADOW_STEP_RST = 1;
    localparam int unsigned SHADOW_HP_RST   = 1;

endpackage

// File: rtl/wave_phase_cnt.sv
// Square-wave half-period counter: counts 0..limit_i-1 while enabled and
// flags the last cycle of each half period on tc_o.
module wave_phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // limit_i is never zero; the parent floors it to one
    assign tc_o = (cnt_q == (limit_i - ONE));

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (clr_i || tc_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/param_wave_gen.sv
// Square / sawtooth / triangle generator. Amplitude, step and half-period are
// shadowed at the start of every period so a running period is never disturbed.
module param_wave_gen
    import wave_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       wave_sel,
    input  logic [WIDTH-1:0] amp,
    input  logic [WIDTH-1:0] step,
    input  logic [CNT_W-1:0] half_per,
    output logic [WIDTH-1:0] wave,
    output logic             sync
);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v);
        return {1'b0, v};
    endfunction

    function automatic logic [WIDTH-1:0] step_floor(input logic [WIDTH-1:0] v);
        return (v == '0) ? ONE_W : v;
    endfunction

    function automatic logic [CNT_W-1:0] hp_floor(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE_C : v;
    endfunction

    wave_mode_e       mode_in;
    wave_mode_e       sel_q, sel_d;
    tri_dir_e         dir_q, dir_d;
    logic             half_q, half_d;
    logic [WIDTH-1:0] wave_q, wave_d;
    logic             sync_q, sync_d;
    logic [WIDTH-1:0] amp_q;
    logic [WIDTH-1:0] step_q;
    logic [CNT_W-1:0] hp_q;

    logic [WIDTH-1:0] step_eff;
    logic [CNT_W-1:0] hp_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   amp_ext;
    logic             mode_chg;
    logic             cnt_clr;
    logic             tc;

    assign mode_in  = wave_mode_e'(wave_sel);
    assign mode_chg = (mode_in != sel_q);
    assign step_eff = step_floor(step_q);
    assign hp_eff   = hp_floor(hp_q);
    // One extra bit keeps wave+step from wrapping before the amplitude compare
    assign sum_ext  = ext(wave_q) + ext(step_eff);
    assign amp_ext  = ext(amp_q);
    assign cnt_clr  = mode_chg || (sel_q != SQUARE);

    wave_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .clr_i   (cnt_clr),
        .limit_i (hp_eff),
        .tc_o    (tc)
    );

    always_comb begin
        sel_d  = sel_q;
        dir_d  = dir_q;
        half_d = half_q;
        wave_d = wave_q;
        sync_d = 1'b0;
        if (en) begin
            if (mode_chg) begin
                sel_d  = mode_in;
                dir_d  = DIR_UP;
                half_d = 1'b0;
                wave_d = '0;
                sync_d = (mode_in != OFF);
            end else begin
                case (sel_q)
                    SQUARE: begin
                        if (tc) begin
                            half_d = ~half_q;
                            wave_d = half_q ? '0 : amp_q;
                            sync_d = half_q;
                        end
                    end
                    SAW: begin
                        if (sum_ext > amp_ext) begin
                            wave_d = '0;
                            sync_d = 1'b1;
                        end else begin
                            wave_d = sum_ext[WIDTH-1:0];
                        end
                    end
                    TRI: begin
                        // A zero peak degenerates to a one-sample period
                        if (amp_q == '0) begin
                            wave_d = '0;
                            dir_d  = DIR_UP;
                            sync_d = 1'b1;
                        end else if (dir_q == DIR_UP) begin
                            if (sum_ext >= amp_ext) begin
                                wave_d = amp_q;
                                dir_d  = DIR_DOWN;
                            end else begin
                                wave_d = sum_ext[WIDTH-1:0];
                            end
                        end else if (ext(wave_q) <= ext(step_eff)) begin
                            wave_d = '0;
                            dir_d  = DIR_UP;
                            sync_d = 1'b1;
                        end else begin
                            wave_d = wave_q - step_eff;
                        end
                    end
                    default: begin
                        wave_d = '0;
                        dir_d  = DIR_UP;
                        half_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= OFF;
            dir_q  <= DIR_UP;
            half_q <= 1'b0;
            wave_q <= '0;
            sync_q <= 1'b0;
            amp_q  <= WIDTH'(SHADOW_AMP_RST);
            step_q <= WIDTH'(SHADOW_STEP_RST);
            hp_q   <= CNT_W'(SHADOW_HP_RST);
        end else begin
            sel_q  <= sel_d;
            dir_q  <= dir_d;
            half_q <= half_d;
            wave_q <= wave_d;
            sync_q <= sync_d;
            if (sync_d) begin
                amp_q  <= amp;
                step_q <= step;
                hp_q   <= half_per;
            end
        end
    end

    assign wave = wave_q;
    assign sync = sync_q;

endmodule

// File: tb/tb_param_wave_gen.sv
// Bench for param_wave_gen: directed vectors plus randomized run against a
// period-list reference model, on a 5-bit and an 8-bit instance.
module tb_param_wave_gen;

    typedef struct {
        int en;
        int sel;
        int amp;
        int stp;
        int hp;
        int ew;
        int es;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] sel;
    logic [7:0] hp;
    logic [4:0] amp5, step5;
    logic [7:0] amp8, step8;
    logic [4:0] w5;
    logic       s5;
    logic [7:0] w8;
    logic       s8;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each period is expanded into a list of samples
    int mbuf [2][1024];
    int m_len [2];
    int m_pos [2];
    int m_sel [2];
    int m_wave [2];
    int m_sync [2];

    param_wave_gen #(.WIDTH(5), .CNT_W(8)) u5 (
        .clk(clk), .rst_n(rst_n), .en(en), .wave_sel(sel),
        .amp(amp5), .step(step5), .half_per(hp), .wave(w5), .sync(s5)
    );

    param_wave_gen #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .en(en), .wave_sel(sel),
        .amp(amp8), .step(step8), .half_per(hp), .wave(w8), .sync(s8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk5(input string nm, input int ew, input int es);
        chk({nm, ".wave"}, int'(w5), ew);
        chk({nm, ".sync"}, int'(s5), es);
    endtask

    task automatic build(input int i, input int mode, input int a, input int st, input int h);
        int n;
        int v;
        n = 0;
        if (st == 0) st = 1;
        if (h == 0) h = 1;
        if (mode == 0) begin
            for (int k = 0; k < 2 * h; k++) begin
                mbuf[i][n] = (k < h) ? 0 : a;
                n++;
            end
        end else if (a == 0) begin
            mbuf[i][0] = 0;
            n = 1;
        end else if (mode == 1) begin
            v = 0;
            while (v <= a) begin
                mbuf[i][n] = v;
                n++;
                v += st;
            end
        end else begin
            v = 0;
            mbuf[i][0] = 0;
            n = 1;
            while (1) begin
                if (v + st >= a) begin
                    v = a;
                    mbuf[i][n] = v;
                    n++;
                    break;
                end
                v += st;
                mbuf[i][n] = v;
                n++;
            end
            while (v > st) begin
                v -= st;
                mbuf[i][n] = v;
                n++;
            end
        end
        m_len[i] = n;
        m_pos[i] = 0;
    endtask

    task automatic model_step(input int i);
        int a;
        int st;
        a  = (i == 0) ? int'(amp5) : int'(amp8);
        st = (i == 0) ? int'(step5) : int'(step8);
        if (!rst_n) begin
            m_sel[i] = 3; m_wave[i] = 0; m_sync[i] = 0; m_len[i] = 0; m_pos[i] = 0;
        end else if (!en) begin
            m_sync[i] = 0;
        end else if (int'(sel) != m_sel[i] || (m_sel[i] != 3 && m_pos[i] >= m_len[i])) begin
            m_sel[i] = int'(sel);
            if (m_sel[i] == 3) begin
                m_wave[i] = 0; m_sync[i] = 0; m_len[i] = 0; m_pos[i] = 0;
            end else begin
                build(i, m_sel[i], a, st, int'(hp));
                m_wave[i] = mbuf[i][0];
                m_sync[i] = 1;
                m_pos[i] = 1;
            end
        end else if (m_sel[i] == 3) begin
            m_wave[i] = 0;
            m_sync[i] = 0;
        end else begin
            m_wave[i] = mbuf[i][m_pos[i]];
            m_sync[i] = 0;
            m_pos[i]++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    function automatic vec_t mk(input int e, input int s, input int a, input int st,
                                input int h, input int ew, input int es);
        vec_t v;
        v.en = e; v.sel = s; v.amp = a; v.stp = st; v.hp = h; v.ew = ew; v.es = es;
        return v;
    endfunction

    initial begin : main
        vec_t tbl[$];
        int saw_w [9]  = '{0, 3, 6, 9, 12, 15, 18, 0, 3};
        int tri_w [12] = '{0, 4, 8, 12, 16, 20, 16, 12, 8, 4, 0, 4};
        int d_w [11]   = '{6, 9, 12, 15, 18, 0, 3, 6, 9, 0, 3};

        for (int i = 0; i < 2; i++) begin
            m_sel[i] = 3; m_wave[i] = 0; m_sync[i] = 0; m_len[i] = 0; m_pos[i] = 0;
        end
        rst_n = 1'b0; en = 1'b0; sel = 2'b11; hp = 8'd10;
        amp5 = 5'd20; step5 = 5'd3; amp8 = 8'd200; step8 = 8'd7;
        cycle();
        cycle();
        chk("rst.w5", int'(w5), 0);
        chk("rst.s5", int'(s5), 0);
        chk("rst.w8", int'(w8), 0);
        chk("rst.s8", int'(s8), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++)
            tbl.push_back(mk(1, 1, 20, 3, 10, saw_w[k], (k == 0 || k == 7) ? 1 : 0));
        for (int k = 0; k < 12; k++)
            tbl.push_back(mk(1, 2, 20, 4, 10, tri_w[k], (k == 0 || k == 10) ? 1 : 0));

        foreach (tbl[i]) begin
            en    = (tbl[i].en != 0);
            sel   = 2'(tbl[i].sel);
            amp5  = 5'(tbl[i].amp);
            step5 = 5'(tbl[i].stp);
            hp    = 8'(tbl[i].hp);
            cycle();
            chk5($sformatf("tbl%0d", i), tbl[i].ew, tbl[i].es);
        end

        // square, amp 20, half period 10
        sel = 2'b00; amp5 = 5'd20; hp = 8'd10;
        for (int k = 0; k < 40; k++) begin
            cycle();
            chk5($sformatf("sq%0d", k), ((k % 20) < 10) ? 0 : 20, (k % 20 == 0) ? 1 : 0);
        end

        // 8-bit saw must not wrap past the peak
        sel = 2'b01; amp8 = 8'd255; step8 = 8'd200;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk($sformatf("w8saw%0d.wave", k), int'(w8), (k % 2 == 0) ? 0 : 200);
            chk($sformatf("w8saw%0d.sync", k), int'(s8), (k % 2 == 0) ? 1 : 0);
        end

        // triangle, freeze with en low, mode switch, mode change during freeze
        sel = 2'b10; amp5 = 5'd20; step5 = 5'd4;
        cycle(); chk5("triA0", 0, 1);
        cycle(); chk5("triA1", 4, 0);
        cycle(); chk5("triA2", 8, 0);
        cycle(); chk5("triA3", 12, 0);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk5($sformatf("frz%0d", k), 12, 0);
        end
        en = 1'b1;
        cycle(); chk5("triB0", 16, 0);
        cycle(); chk5("triB1", 20, 0);
        cycle(); chk5("triB2", 16, 0);
        cycle(); chk5("triB3", 12, 0);
        sel = 2'b00;
        cycle(); chk5("tri2sq", 0, 1);
        sel = 2'b10;
        cycle(); chk5("sq2tri0", 0, 1);
        cycle(); chk5("sq2tri1", 4, 0);
        cycle(); chk5("sq2tri2", 8, 0);
        en = 1'b0; sel = 2'b01;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk5($sformatf("selfrz%0d", k), 8, 0);
        end
        en = 1'b1; step5 = 5'd3;
        cycle(); chk5("selrst0", 0, 1);
        cycle(); chk5("selrst1", 3, 0);

        // amplitude change mid-period only affects the next period
        amp5 = 5'd10;
        for (int k = 0; k < 11; k++) begin
            cycle();
            chk5($sformatf("ampchg%0d", k), d_w[k], (k == 5 || k == 9) ? 1 : 0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk5("async_rst", 0, 0);
        chk("async_rst.w8", int'(w8), 0);
        cycle();
        rst_n = 1'b1;
        cycle(); chk5("postrst0", 0, 1);
        cycle(); chk5("postrst1", 3, 0);

        // zero amplitude in every mode, then off
        sel = 2'b10; amp5 = 5'd0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk5($sformatf("tri0amp%0d", k), 0, 1);
        end
        sel = 2'b01;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk5($sformatf("saw0amp%0d", k), 0, 1);
        end
        sel = 2'b00; hp = 8'd2;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk5($sformatf("sq0amp%0d", k), 0, (k % 4 == 0) ? 1 : 0);
        end
        sel = 2'b11; amp5 = 5'd17;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk5($sformatf("off%0d", k), 0, 0);
        end

        // randomized run against the reference model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) sel = 2'($urandom_range(0, 3));
            en    = ($urandom_range(0, 7) != 0);
            amp5  = 5'($urandom);
            step5 = 5'($urandom_range(0, 7));
            amp8  = 8'($urandom);
            step8 = 8'($urandom_range(0, 40));
            hp    = 8'($urandom_range(0, 6));
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
            chk($sformatf("rnd%0d.w5", k), int'(w5), m_wave[0]);
            chk($sformatf("rnd%0d.s5", k), int'(s5), m_sync[0]);
            chk($sformatf("rnd%0d.w8", k), int'(w8), m_wave[1]);
            chk($sformatf("rnd%0d.s8", k), int'(s8), m_sync[1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
